// File: rtl/digital_clock_pkg.sv
// Shared types and helpers for the parametrised digital clock.
package digital_clock_pkg;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
  } time_t;

  localparam logic [4:0] MAX_HH = 5'd23;
  localparam logic [5:0] MAX_MM = 6'd59;
  localparam logic [5:0] MAX_SS = 6'd59;

  typedef enum logic {LD_IDLE, LD_BUSY} ld_state_e;

  // 0..63 -> {tens, ones}; tens found by threshold compare to avoid a divider
  function automatic logic [7:0] bin2bcd(input logic [5:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    for (int k = 1; k <= 6; k++)
      if (bin >= 6'(10 * k)) tens = 4'(k);
    ones = 4'(bin - 6'(tens) * 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Divides the system clock down to one wrap pulse per second while run is high.
module clock_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  // wrap flags the edge on which the counter rolls over, not the cycle after
  assign wrap = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= wrap ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/digital_clock_param.sv
// hh:mm:ss clock with prescaler, checked time loads, 12/24h BCD display.
// Optional alarm compare enabled by defining DIGITAL_CLOCK_ALARM_EN.
module digital_clock_param
  import digital_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        load_valid,
  input  logic [16:0] load_time,
  output logic        load_ready,
  output logic        load_err,
  output logic        tick_1hz,
  output logic [3:0]  sec_1s,
  output logic [3:0]  sec_10s,
  output logic [3:0]  min_1s,
  output logic [3:0]  min_10s,
  output logic [3:0]  hr_1s,
  output logic [3:0]  hr_10s,
  output logic        pm,
  input  logic        alarm_set,
  input  logic [10:0] alarm_time,
  input  logic        alarm_arm,
  input  logic        alarm_ack,
  output logic        alarm_irq
);

  time_t     cur, nxt_inc, ld;
  ld_state_e state, state_nxt;
  logic      wrap, ld_ok, accept, do_load, inc;
  logic [5:0] hh_disp;

  assign ld      = time_t'(load_time);
  assign ld_ok   = (ld.hh <= MAX_HH) && (ld.mm <= MAX_MM) && (ld.ss <= MAX_SS);
  assign accept  = load_valid && load_ready;
  assign do_load = accept && ld_ok;
  // a valid load on the wrap edge swallows that second
  assign inc     = wrap && !do_load;

  clock_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC), .CNT_W(CNT_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (do_load),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE: if (load_valid) state_nxt = LD_BUSY;
      LD_BUSY: state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign load_ready = (state == LD_IDLE);

  always_comb begin
    nxt_inc = cur;
    if (cur.ss == MAX_SS) begin
      nxt_inc.ss = '0;
      if (cur.mm == MAX_MM) begin
        nxt_inc.mm = '0;
        nxt_inc.hh = (cur.hh == MAX_HH) ? '0 : cur.hh + 5'd1;
      end else begin
        nxt_inc.mm = cur.mm + 6'd1;
      end
    end else begin
      nxt_inc.ss = cur.ss + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick_1hz <= inc;
      if (do_load)  cur <= ld;
      else if (inc) cur <= nxt_inc;
      if (accept)   load_err <= !ld_ok;
    end
  end

  always_comb begin
    hh_disp = {1'b0, cur.hh};
    if (mode_12h) begin
      if (cur.hh == 5'd0)       hh_disp = 6'd12;
      else if (cur.hh > 5'd12)  hh_disp = 6'(cur.hh) - 6'd12;
    end
  end

  assign pm                = (cur.hh >= 5'd12);
  assign {hr_10s, hr_1s}   = bin2bcd(hh_disp);
  assign {min_10s, min_1s} = bin2bcd(cur.mm);
  assign {sec_10s, sec_1s} = bin2bcd(cur.ss);

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [4:0] al_hh;
  logic [5:0] al_mm;
  logic       irq;
  logic       set_ok, al_hit;

  assign set_ok = (alarm_time[10:6] <= MAX_HH) && (alarm_time[5:0] <= MAX_MM);
  // only counting into hh:mm:00 fires; loads never do
  assign al_hit = inc && alarm_arm && (nxt_inc.ss == 6'd0) &&
                  (nxt_inc.hh == al_hh) && (nxt_inc.mm == al_mm);

  always_ff @(posedge clk) begin
    if (rst) begin
      al_hh <= '0;
      al_mm <= '0;
      irq   <= 1'b0;
    end else begin
      if (alarm_set && set_ok) {al_hh, al_mm} <= alarm_time;
      if (al_hit)              irq <= 1'b1;
      else if (alarm_ack)      irq <= 1'b0;
    end
  end

  assign alarm_irq = irq;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_set, alarm_time, alarm_arm, alarm_ack};
  assign alarm_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_digital_clock_param.sv
// Directed scoreboard bench for digital_clock_param at TICKS_PER_SEC=4.
module tb_digital_clock_param;

  localparam int TPS = 4;
`ifdef DIGITAL_CLOCK_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run, mode_12h, load_valid;
  logic [16:0] load_time;
  logic        load_ready, load_err, tick_1hz, pm;
  logic [3:0]  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
  logic        alarm_set, alarm_arm, alarm_ack, alarm_irq;
  logic [10:0] alarm_time;

  digital_clock_param #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .load_valid(load_valid), .load_time(load_time),
    .load_ready(load_ready), .load_err(load_err), .tick_1hz(tick_1hz),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .hr_1s(hr_1s), .hr_10s(hr_10s), .pm(pm),
    .alarm_set(alarm_set), .alarm_time(alarm_time), .alarm_arm(alarm_arm),
    .alarm_ack(alarm_ack), .alarm_irq(alarm_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [28:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [28:0] obs;
  assign obs = {tick_1hz, pm, load_ready, load_err, alarm_irq,
                hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};

  // expected snapshot; hd is the displayed hour value
  function automatic logic [28:0] mk(bit tick, bit p, bit rdy, bit err, bit irq,
                                     int hd, int mm, int ss);
    return {tick, p, rdy, err, irq, 4'(hd / 10), 4'(hd % 10),
            4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check();
    sb_t s;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      s = sb.pop_front();
      assert (obs === s.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
      end
    end
  endtask

  // push expectation, advance n edges, compare
  task automatic sc(int n, string tag, logic [28:0] e);
    sb.push_back('{tag, e});
    step(n);
    check();
  endtask

  // one-cycle load request, compare right after the accepting edge
  task automatic ldc(int h, int m, int s, string tag, logic [28:0] e);
    load_valid = 1'b1;
    load_time  = {5'(h), 6'(m), 6'(s)};
    sb.push_back('{tag, e});
    step(1);
    load_valid = 1'b0;
    check();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mode_12h = 1'b0; load_valid = 1'b0; load_time = '0;
    alarm_set = 1'b0; alarm_time = '0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    step(2);
    sc(0, "reset", mk(0, 0, 1, 0, 0, 0, 0, 0));
    rst = 1'b0; run = 1'b1;

    // first second, then pause mid-count
    sc(3, "s1_pre",     mk(0, 0, 1, 0, 0, 0, 0, 0));
    sc(1, "s1_tick",    mk(1, 0, 1, 0, 0, 0, 0, 1));
    sc(2, "s1_cnt2",    mk(0, 0, 1, 0, 0, 0, 0, 1));
    run = 1'b0;
    sc(5, "s1_hold",    mk(0, 0, 1, 0, 0, 0, 0, 1));
    run = 1'b1;
    sc(1, "s1_resume",  mk(0, 0, 1, 0, 0, 0, 0, 1));
    sc(1, "s1_tick2",   mk(1, 0, 1, 0, 0, 0, 0, 2));

    // carries
    ldc(23, 59, 58, "s2_load", mk(0, 1, 0, 0, 0, 23, 59, 58));
    sc(3, "s2_pre",     mk(0, 1, 1, 0, 0, 23, 59, 58));
    sc(1, "s2_59",      mk(1, 1, 1, 0, 0, 23, 59, 59));
    sc(4, "s2_daywrap", mk(1, 0, 1, 0, 0, 0, 0, 0));
    ldc(9, 59, 59, "s2_ld9", mk(0, 0, 0, 0, 0, 9, 59, 59));
    sc(4, "s2_hcarry",  mk(1, 1'b1 & 1'b0, 1, 0, 0, 10, 0, 0));
    ldc(0, 0, 59, "s2_ld0059", mk(0, 0, 0, 0, 0, 0, 0, 59));
    sc(4, "s2_mcarry",  mk(1, 0, 1, 0, 0, 0, 1, 0));

    // invalid load keeps prescaler running, then valid load clears error
    sc(2, "s3_pre",     mk(0, 0, 1, 0, 0, 0, 1, 0));
    ldc(24, 0, 0, "s3_bad", mk(0, 0, 0, 1, 0, 0, 1, 0));
    sc(1, "s3_tick",    mk(1, 0, 1, 1, 0, 0, 1, 1));
    run = 1'b0;
    load_valid = 1'b1; load_time = {5'd10, 6'd20, 6'd30};
    sc(1, "s3_good",    mk(0, 0, 0, 0, 0, 10, 20, 30));
    load_time = {5'd25, 6'd0, 6'd0};
    sc(1, "s3_busy_ign", mk(0, 0, 1, 0, 0, 10, 20, 30));
    load_valid = 1'b0;

    // display modes
    mode_12h = 1'b1;
    ldc(0, 0, 0, "s4_h0", mk(0, 0, 0, 0, 0, 12, 0, 0));
    sc(1, "s4_h0_idle", mk(0, 0, 1, 0, 0, 12, 0, 0));
    ldc(12, 30, 0, "s4_h12", mk(0, 1, 0, 0, 0, 12, 30, 0));
    step(1);
    ldc(13, 5, 9, "s4_h13", mk(0, 1, 0, 0, 0, 1, 5, 9));
    step(1);
    mode_12h = 1'b0;
    sc(0, "s4_24h_h13", mk(0, 1, 1, 0, 0, 13, 5, 9));
    mode_12h = 1'b1;
    ldc(23, 0, 0, "s4_h23", mk(0, 1, 0, 0, 0, 11, 0, 0));
    step(1);
    mode_12h = 1'b0;

    // load on the wrap edge
    run = 1'b1;
    ldc(1, 0, 0, "s5_sync", mk(0, 0, 0, 0, 0, 1, 0, 0));
    sc(3, "s5_pre",     mk(0, 0, 1, 0, 0, 1, 0, 0));
    ldc(5, 6, 7, "s5_ldwrap", mk(0, 0, 0, 0, 0, 5, 6, 7));
    sc(3, "s5_notick",  mk(0, 0, 1, 0, 0, 5, 6, 7));
    sc(1, "s5_tick",    mk(1, 0, 1, 0, 0, 5, 6, 8));

    // alarm
    alarm_set = 1'b1; alarm_time = {5'd7, 6'd0};
    step(1);
    alarm_set = 1'b0; alarm_arm = 1'b1;
    ldc(6, 59, 59, "s6_load", mk(0, 0, 0, 0, 0, 6, 59, 59));
    sc(3, "s6_pre",     mk(0, 0, 1, 0, 0, 6, 59, 59));
    sc(1, "s6_irq",     mk(1, 0, 1, 0, AL, 7, 0, 0));
    alarm_ack = 1'b1;
    sc(1, "s6_ack",     mk(0, 0, 1, 0, 0, 7, 0, 0));
    alarm_ack = 1'b0;
    ldc(7, 0, 0, "s6_ld_noirq", mk(0, 0, 0, 0, 0, 7, 0, 0));
    sc(4, "s6_after",   mk(1, 0, 1, 0, 0, 7, 0, 1));

    // reset while BUSY with error set
    ldc(31, 0, 0, "rst_pre", mk(0, 0, 0, 1, 0, 7, 0, 1));
    rst = 1'b1;
    sc(1, "rst_busy",   mk(0, 0, 1, 0, 0, 0, 0, 0));
    rst = 1'b0; run = 1'b0; alarm_arm = 1'b0;
    sc(2, "rst_after",  mk(0, 0, 1, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
